// File: rtl/hilo_muldiv_pkg.sv
// Shared types and ALU-decoder control codes for the HI/LO multiply/divide unit.
// The control codes must match the ALU decoder's encoding.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [4:0] MULT_CONTROL  = 5'b10000;
    localparam logic [4:0] MULTU_CONTROL = 5'b10001;
    localparam logic [4:0] DIV_CONTROL   = 5'b10010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;
    localparam logic [4:0] MFHI_CONTROL  = 5'b10110;
    localparam logic [4:0] MFLO_CONTROL  = 5'b10111;

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per enabled step.
// Outputs show the quotient/remainder as they will be after the current step.
module div_core (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;

    // r_quo shifts dividend bits out at the top while quotient bits enter at the bottom
    assign w_shift     = {r_rem, r_quo[31]};
    assign w_diff      = w_shift - {1'b0, r_dvs};
    assign w_qbit      = ~w_diff[32];
    assign o_remainder = w_qbit ? w_diff[31:0] : w_shift[31:0];
    assign o_quotient  = {r_quo[30:0], w_qbit};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= o_remainder;
            r_quo <= o_quotient;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Stalls the pipeline while a MULT/DIV is in flight, then commits to HI/LO.
import hilo_muldiv_pkg::*;

module hilo_muldiv #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int              CNT_W     = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic              r_mul_signed;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [CNT_W-1:0]  r_count;

    logic              w_hi_we;
    logic              w_lo_we;
    logic [31:0]       w_hi_d;
    logic [31:0]       w_lo_d;
    logic              w_mul_load;
    logic              w_div_load;
    logic              w_div_step;
    logic              w_div_signed;
    logic [31:0]       w_abs_a;
    logic [31:0]       w_abs_b;
    logic [63:0]       w_prod;
    logic [31:0]       w_quo;
    logic [31:0]       w_rem;
    logic [31:0]       w_quo_fix;
    logic [31:0]       w_rem_fix;

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    assign w_div_signed = (alucontrol == DIV_CONTROL);
    assign w_abs_a      = (w_div_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_abs_b      = (w_div_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign-extend into 64 bits so one multiplier serves both MULT and MULTU
    assign w_prod = {{32{r_mul_signed & r_opa[31]}}, r_opa}
                  * {{32{r_mul_signed & r_opb[31]}}, r_opb};

    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (32'd0 - w_quo) : w_quo;
    assign w_rem_fix = r_sign_a ? (32'd0 - w_rem) : w_rem;

    div_core u_div_core (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_div_load),
        .i_step      (w_div_step),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        stall_req    = 1'b0;
        done         = 1'b0;
        w_hi_we      = 1'b0;
        w_lo_we      = 1'b0;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        w_mul_load   = 1'b0;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (alucontrol)
                        MTHI_CONTROL: begin
                            w_hi_we = 1'b1;
                            w_hi_d  = src_a;
                        end
                        MTLO_CONTROL: begin
                            w_lo_we = 1'b1;
                            w_lo_d  = src_a;
                        end
                        MULT_CONTROL, MULTU_CONTROL: begin
                            stall_req    = 1'b1;
                            w_mul_load   = 1'b1;
                            w_next_state = ST_MUL;
                        end
                        DIV_CONTROL, DIVU_CONTROL: begin
                            stall_req = 1'b1;
                            if (src_b == 32'd0) begin
                                w_next_state = ST_DONE;
                            end else begin
                                w_div_load   = 1'b1;
                                w_next_state = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                stall_req    = 1'b1;
                w_hi_we      = 1'b1;
                w_lo_we      = 1'b1;
                w_hi_d       = w_prod[63:32];
                w_lo_d       = w_prod[31:0];
                w_next_state = ST_DONE;
            end
            ST_DIV: begin
                stall_req  = 1'b1;
                w_div_step = 1'b1;
                if (r_count == LAST_ITER) begin
                    w_hi_we      = 1'b1;
                    w_lo_we      = 1'b1;
                    w_hi_d       = w_rem_fix;
                    w_lo_d       = w_quo_fix;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // A flush cancels everything scheduled for this edge; an in-flight op still stalls this cycle
        if (flush) begin
            w_next_state = ST_IDLE;
            w_hi_we      = 1'b0;
            w_lo_we      = 1'b0;
            w_mul_load   = 1'b0;
            w_div_load   = 1'b0;
            w_div_step   = 1'b0;
            if (r_state == ST_IDLE) stall_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_hi_we) r_hi <= w_hi_d;
            if (w_lo_we) r_lo <= w_lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_opa        <= '0;
            r_opb        <= '0;
            r_mul_signed <= 1'b0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_count      <= '0;
        end else begin
            if (w_mul_load) begin
                r_opa        <= src_a;
                r_opb        <= src_b;
                r_mul_signed <= (alucontrol == MULT_CONTROL);
            end
            if (w_div_load) begin
                r_sign_a <= w_div_signed & src_a[31];
                r_sign_b <= w_div_signed & src_b[31];
                r_count  <= '0;
            end else if (w_div_step) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv: results, stall/done timing,
// divide-by-zero, flush and mid-operation reset.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks;
    int failures;

    hilo_muldiv #(.DIV_ITERS(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall_req  (stall_req),
        .done       (done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] c,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic f);
        start      = s;
        alucontrol = c;
        src_a      = a;
        src_b      = b;
        flush      = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a long op, count stall cycles, then check done and results in the first non-stalled cycle
    task automatic doLongOp(input string tag, input logic [4:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input int expStall, input logic [31:0] expHi,
                            input logic [31:0] expLo);
        int n;
        n = 0;
        applyStimulus(1'b1, c, a, b, 1'b0);
        #1;
        while (stall_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checkOutput({tag, "_stall_cycles"}, 32'(n), 32'(expStall));
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_hi"}, hi_o, expHi);
        checkOutput({tag, "_lo"}, lo_o, expLo);
        applyStimulus(1'b0, c, a, b, 1'b0);
        tick();
        checkOutput({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_no_reaccept"}, {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_hi", hi_o, 32'd0);
        checkOutput("reset_lo", lo_o, 32'd0);
        resetn = 1'b1;
        tick();

        doLongOp("mult",  MULT_CONTROL,  32'hFFFFFFFE, 32'd3, 2, 32'hFFFFFFFF, 32'hFFFFFFFA);
        doLongOp("multu", MULTU_CONTROL, 32'hFFFFFFFE, 32'd3, 2, 32'h00000002, 32'hFFFFFFFA);
        doLongOp("div_neg7_2", DIV_CONTROL, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        doLongOp("divu_7_2", DIVU_CONTROL, 32'd7, 32'd2, 33, 32'd1, 32'd3);
        doLongOp("div_min_m1", DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);
        doLongOp("divu_5_9", DIVU_CONTROL, 32'd5, 32'd9, 33, 32'd5, 32'd0);

        // MTHI/MTLO: no stall, value visible the next cycle
        applyStimulus(1'b1, MTHI_CONTROL, 32'h12345678, 32'd0, 1'b0);
        #1;
        checkOutput("mthi_no_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("mthi_not_yet", hi_o, 32'd5);
        tick();
        checkOutput("mthi_hi", hi_o, 32'h12345678);
        applyStimulus(1'b1, MTLO_CONTROL, 32'h9ABCDEF0, 32'd0, 1'b0);
        tick();
        checkOutput("mtlo_lo", lo_o, 32'h9ABCDEF0);
        checkOutput("mtlo_hi_kept", hi_o, 32'h12345678);

        // Flush suppresses an MTHI write; an unknown code is ignored
        applyStimulus(1'b1, MTHI_CONTROL, 32'hDEADBEEF, 32'd0, 1'b1);
        tick();
        checkOutput("flush_mthi", hi_o, 32'h12345678);
        applyStimulus(1'b1, 5'b00010, 32'hDEADBEEF, 32'd1, 1'b0);
        #1;
        checkOutput("ignored_code_stall", {31'd0, stall_req}, 32'd0);
        tick();
        checkOutput("ignored_code_hi", hi_o, 32'h12345678);

        // Divide by zero leaves preloaded HI/LO untouched
        applyStimulus(1'b1, MTHI_CONTROL, 32'hAAAA0000, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, MTLO_CONTROL, 32'h0000BBBB, 32'd0, 1'b0);
        tick();
        doLongOp("div_by_zero", DIV_CONTROL, 32'd1234, 32'd0, 1, 32'hAAAA0000, 32'h0000BBBB);

        // Flush at T+10 of a DIV, then MULTU 4x5 issued at T+11
        applyStimulus(1'b1, DIV_CONTROL, 32'd100, 32'd7, 1'b0);
        repeat (10) tick();
        applyStimulus(1'b1, DIV_CONTROL, 32'd100, 32'd7, 1'b1);
        #1;
        checkOutput("flush_cycle_stall", {31'd0, stall_req}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("after_flush_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("after_flush_done", {31'd0, done}, 32'd0);
        checkOutput("after_flush_hi", hi_o, 32'hAAAA0000);
        checkOutput("after_flush_lo", lo_o, 32'h0000BBBB);
        applyStimulus(1'b1, MULTU_CONTROL, 32'd4, 32'd5, 1'b0);
        #1;
        checkOutput("post_flush_issue_stall", {31'd0, stall_req}, 32'd1);
        tick();
        tick();
        checkOutput("post_flush_done", {31'd0, done}, 32'd1);
        checkOutput("post_flush_lo", lo_o, 32'd20);
        checkOutput("post_flush_hi", hi_o, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();

        // Reset in the middle of a DIV
        applyStimulus(1'b1, DIVU_CONTROL, 32'd1000, 32'd3, 1'b0);
        repeat (5) tick();
        resetn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();
        resetn = 1'b1;
        #1;
        checkOutput("midreset_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_hi", hi_o, 32'd0);
        checkOutput("midreset_lo", lo_o, 32'd0);

        doLongOp("divu_after_reset", DIVU_CONTROL, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO register pair for the MIPS datapath. It sits in EX beside the combinational ALU. It consumes the 5-bit `alucontrol` codes produced by the ALU decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. While an operation is in flight it stalls the pipeline through `stall_req`, then commits the result to HI/LO.

## Interface
Parameters:
- `DIV_ITERS`, default 32: quotient bits produced, one per cycle. Fixed for 32-bit operands.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: EX holds a valid instruction whose `alucontrol` is meaningful this cycle.
- `alucontrol` in 5: control code from the ALU decoder; codes other than the eight listed above are ignored.
- `src_a` in 32: rs operand (dividend, multiplicand, MTHI/MTLO data).
- `src_b` in 32: rt operand (divisor, multiplier).
- `flush` in 1: exception/cancel; aborts any operation in flight.
- `stall_req` out 1: freeze IF/ID/EX while high.
- `done` out 1: one-cycle pulse when a MULT/DIV result has committed.
- `hi_o` out 32: current HI register.
- `lo_o` out 32: current LO register.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Reset (`resetn`=0 at edge) puts every output in a known state:
  - state=IDLE, HI=LO=0, counter=0.
  - `stall_req`=0, `done`=0.
  - Any operation in flight is abandoned.
- `flush` takes priority over `start`:
  - Next state is IDLE.
  - Any HI/LO write scheduled for that edge is suppressed.
- IDLE with `start`=1:
  - MTHI/MTLO: HI (or LO) <= `src_a` at the edge. No stall. State stays IDLE.
  - MULT/MULTU: latch operands; next state MUL.
  - DIV/DIVU with `src_b`≠0: latch |a|, |b| (signed) or raw values (unsigned), plus both sign bits; clear counter; next state DIV.
  - DIV/DIVU with `src_b`=0: HI/LO unchanged; next state DONE.
  - MFHI/MFLO: no state change. The datapath reads `hi_o`/`lo_o` combinationally.
- MUL state:
  - {HI,LO} <= signed or unsigned 64-bit product of the latched operands.
  - Next state DONE.
- DIV state:
  - One restoring iteration per cycle on a 33-bit partial remainder; counter increments.
  - On the final iteration (counter=`DIV_ITERS`-1), commit LO=quotient, HI=remainder. Next state DONE.
  - Signed fixup: quotient negated if sign_a^sign_b; remainder carries sign_a.
  - 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- DONE state:
  - `done`=1 and `stall_req`=0; the pipeline advances this cycle.
  - Next state is IDLE unconditionally. The still-present `start` is not re-accepted.

## Timing
- `stall_req` = (state==IDLE & `start` & op∈{MULT,MULTU,DIV,DIVU} & !`flush`) | state∈{MUL,DIV}. This is combinational, so it rises in the issue cycle T.
- MULT/MULTU:
  - `stall_req` high in T and T+1.
  - HI/LO are visible and `done`=1 in T+2.
- DIV/DIVU:
  - `stall_req` high in T through T+32 (33 cycles).
  - HI/LO are visible and `done`=1 in T+33.
- Divide by zero: `stall_req` high in T only; `done` in T+1.
- MTHI/MTLO: new value on `hi_o`/`lo_o` in T+1. Zero stall.
- Flush in cycle F: `stall_req` is low from F+1 and state is IDLE; a new `start` is accepted in F+1.

## Structure
- Shared constants belong in `defines.vh`:
  - `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`
  - `MTHI_CONTROL`, `MTLO_CONTROL`, `MFHI_CONTROL`, `MFLO_CONTROL`
- FSM state encodings and the iteration count are localparams in this block.
- One sub-module, `div_core`: an unsigned iterative restoring divider (operand load, step enable, 32-bit quotient/remainder out). Sign handling, HI/LO and the FSM stay in `hilo_muldiv`.

## Test plan
1. MULT 0xFFFFFFFE×3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA; `stall_req` high exactly 2 cycles, `done` at T+2.
2. DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; `stall_req` high 33 cycles, `done` at T+33.
3. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/9 -> LO=0, HI=5.
4. DIV x/0 with HI/LO preloaded to 0xAAAA0000/0x0000BBBB -> both unchanged; `stall_req` 1 cycle, `done` at T+1.
5. `flush` at T+10 of a DIV -> `stall_req`=0 at T+11, HI/LO unchanged, no `done`; MULTU 4×5 issued at T+11 -> LO=20, HI=0 at T+13.
6. MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> `hi_o`/`lo_o` update on the following cycles; `resetn`=0 mid-DIV -> HI=LO=0, `stall_req`=0 next cycle.
